// File: rtl/debounce_bank.sv
// Multi-channel input debouncer: 2-FF sync, stable-count filter, press/release pulses.
// Optional auto-repeat on held channels is compiled in with `define DEBOUNCE_REPEAT_EN.
module debounce_bank #(
  parameter int N_CH          = 5,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_RATE   = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("debounce_bank: N_CH must be in 1..32");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_bank: STABLE_CYCLES must be at least 2");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("debounce_bank: REPEAT_RATE must be at least 1");
  end

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [N_CH-1:0] sync0;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] level_nxt;
  logic [CW-1:0]   cnt     [N_CH];
  logic [CW-1:0]   cnt_nxt [N_CH];

  always_comb begin
    level_nxt = btn_level;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
      if (sync1[i] != btn_level[i]) begin
        if (cnt[i] == CNT_MAX) begin
          level_nxt[i] = sync1[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pulses are derived from the next level so they line up with the level change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0       <= '0;
      sync1       <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync0       <= btn_in;
      sync1       <= sync0;
      btn_level   <= level_nxt;
      btn_press   <= level_nxt & ~btn_level;
      btn_release <= ~level_nxt & btn_level;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned HW = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
  localparam int unsigned RW = (REPEAT_RATE < 2) ? 1 : $clog2(REPEAT_RATE);
  localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_MAX = RW'(REPEAT_RATE - 1);

  logic [HW-1:0] hold [N_CH];
  logic [RW-1:0] rate [N_CH];

  // Hold counter saturates at the initial delay; the rate counter then spaces later pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_repeat <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        hold[i] <= '0;
        rate[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (level_nxt[i] && btn_level[i]) begin
          if (hold[i] != HOLD_MAX) begin
            hold[i]       <= hold[i] + 1'b1;
            rate[i]       <= '0;
            btn_repeat[i] <= ((hold[i] + 1'b1) == HOLD_MAX);
          end else begin
            btn_repeat[i] <= (rate[i] == RATE_MAX);
            rate[i]       <= (rate[i] == RATE_MAX) ? '0 : rate[i] + 1'b1;
          end
        end else begin
          hold[i]       <= '0;
          rate[i]       <= '0;
          btn_repeat[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (N_CH=3, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
module tb_debounce_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_in;
  logic [2:0] btn_level, btn_press, btn_release, btn_repeat;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(3),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_repeat(btn_repeat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    btn_in = 3'b000;
    tick; tick;
    checks++; if (btn_level !== 3'b000) begin failures++; $display("FAIL reset_level got=%b exp=000", btn_level); end
    checks++; if (btn_press !== 3'b000) begin failures++; $display("FAIL reset_press got=%b exp=000", btn_press); end
    checks++; if (btn_release !== 3'b000) begin failures++; $display("FAIL reset_release got=%b exp=000", btn_release); end
    checks++; if (btn_repeat !== 3'b000) begin failures++; $display("FAIL reset_repeat got=%b exp=000", btn_repeat); end
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      checks++;
      if ({btn_level, btn_press, btn_release} !== 9'b0) begin
        failures++; $display("FAIL reset_release_quiet k=%0d got=%b exp=0", k, {btn_level, btn_press, btn_release});
      end
    end
  endtask

  task automatic test_single_press;
    logic [2:0] el, ep, er;
    @(negedge clk) btn_in = 3'b001;
    for (int e = 0; e <= 6; e++) begin
      tick;
      el = (e >= 5) ? 3'b001 : 3'b000;
      ep = (e == 5) ? 3'b001 : 3'b000;
      checks++; if (btn_level !== el) begin failures++; $display("FAIL press_level e=%0d got=%b exp=%b", e, btn_level, el); end
      checks++; if (btn_press !== ep) begin failures++; $display("FAIL press_pulse e=%0d got=%b exp=%b", e, btn_press, ep); end
      checks++; if (btn_release !== 3'b000) begin failures++; $display("FAIL press_norel e=%0d got=%b exp=000", e, btn_release); end
    end
    @(negedge clk) btn_in = 3'b000;
    for (int e = 0; e <= 6; e++) begin
      tick;
      el = (e >= 5) ? 3'b000 : 3'b001;
      er = (e == 5) ? 3'b001 : 3'b000;
      checks++; if (btn_level !== el) begin failures++; $display("FAIL rel_level e=%0d got=%b exp=%b", e, btn_level, el); end
      checks++; if (btn_release !== er) begin failures++; $display("FAIL rel_pulse e=%0d got=%b exp=%b", e, btn_release, er); end
      checks++; if (btn_press !== 3'b000) begin failures++; $display("FAIL rel_nopress e=%0d got=%b exp=000", e, btn_press); end
    end
  endtask

  task automatic test_glitch;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk) btn_in = (c < 3) ? 3'b010 : 3'b000;
        tick;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'b0) begin
          failures++; $display("FAIL glitch r=%0d c=%0d got=%b exp=0", r, c, {btn_level, btn_press, btn_release, btn_repeat});
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if ({btn_level, btn_press, btn_release} !== 9'b0) begin
        failures++; $display("FAIL glitch_tail k=%0d got=%b exp=0", k, {btn_level, btn_press, btn_release});
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [2:0] ep, er;
    @(negedge clk) btn_in = 3'b111;
    for (int e = 0; e <= 6; e++) begin
      tick;
      ep = (e == 5) ? 3'b111 : 3'b000;
      checks++; if (btn_press !== ep) begin failures++; $display("FAIL sim_press e=%0d got=%b exp=%b", e, btn_press, ep); end
    end
    checks++; if (btn_level !== 3'b111) begin failures++; $display("FAIL sim_level got=%b exp=111", btn_level); end
    @(negedge clk) btn_in = 3'b000;
    for (int e = 0; e <= 6; e++) begin
      tick;
      er = (e == 5) ? 3'b111 : 3'b000;
      checks++; if (btn_release !== er) begin failures++; $display("FAIL sim_release e=%0d got=%b exp=%b", e, btn_release, er); end
      checks++; if (btn_press !== 3'b000) begin failures++; $display("FAIL sim_nopress e=%0d got=%b exp=000", e, btn_press); end
    end
  endtask

  task automatic test_reset_midcount;
    logic [2:0] el, ep;
    @(negedge clk) btn_in = 3'b001;
    for (int k = 0; k < 8; k++) tick;
    checks++; if (btn_level !== 3'b001) begin failures++; $display("FAIL mid_pre_level got=%b exp=001", btn_level); end
    @(negedge clk) btn_in = 3'b101;
    for (int e = 0; e < 4; e++) tick;
    #2 reset = 1'b1;
    #1;
    checks++; if (btn_level !== 3'b000) begin failures++; $display("FAIL mid_async_level got=%b exp=000", btn_level); end
    checks++; if ({btn_press, btn_release, btn_repeat} !== 9'b0) begin failures++; $display("FAIL mid_async_pulses got=%b exp=0", {btn_press, btn_release, btn_repeat}); end
    tick; tick;
    checks++; if ({btn_level, btn_press, btn_release, btn_repeat} !== 12'b0) begin failures++; $display("FAIL mid_held got=%b exp=0", {btn_level, btn_press, btn_release, btn_repeat}); end
    @(negedge clk) reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick;
      el = (e >= 5) ? 3'b101 : 3'b000;
      ep = (e == 5) ? 3'b101 : 3'b000;
      checks++; if (btn_level !== el) begin failures++; $display("FAIL mid_post_level e=%0d got=%b exp=%b", e, btn_level, el); end
      checks++; if (btn_press !== ep) begin failures++; $display("FAIL mid_post_press e=%0d got=%b exp=%b", e, btn_press, ep); end
    end
    @(negedge clk) btn_in = 3'b000;
    for (int k = 0; k < 8; k++) tick;
    checks++; if (btn_level !== 3'b000) begin failures++; $display("FAIL mid_cleanup got=%b exp=000", btn_level); end
  endtask

  task automatic test_repeat;
    logic [2:0] erep, el, er;
    @(negedge clk) btn_in = 3'b001;
    for (int e = 0; e < 5; e++) tick;
    tick;
    checks++; if (btn_press !== 3'b001) begin failures++; $display("FAIL rep_press got=%b exp=001", btn_press); end
    checks++; if (btn_repeat !== 3'b000) begin failures++; $display("FAIL rep_at_press got=%b exp=000", btn_repeat); end
    for (int k = 1; k <= 45; k++) begin
      if (k == 34) @(negedge clk) btn_in = 3'b000;
      tick;
      el = (k < 39) ? 3'b001 : 3'b000;
      er = (k == 39) ? 3'b001 : 3'b000;
`ifdef DEBOUNCE_REPEAT_EN
      erep = (k < 39 && k >= 10 && ((k - 10) % 3) == 0) ? 3'b001 : 3'b000;
`else
      erep = 3'b000;
`endif
      checks++; if (btn_repeat !== erep) begin failures++; $display("FAIL rep_pulse k=%0d got=%b exp=%b", k, btn_repeat, erep); end
      checks++; if (btn_level !== el) begin failures++; $display("FAIL rep_level k=%0d got=%b exp=%b", k, btn_level, el); end
      checks++; if (btn_release !== er) begin failures++; $display("FAIL rep_release k=%0d got=%b exp=%b", k, btn_release, er); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single_press;
    test_glitch;
    test_simultaneous;
    test_reset_midcount;
    test_repeat;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 5, number of independent input channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 1_000_000, consecutive mismatching cycles required to accept a new level (10 ms at 100 MHz); values below 2 SHALL fail elaboration.
REQ-003 Parameter REPEAT_DELAY, default 50_000_000, held-high cycles before the first auto-repeat pulse (0.5 s).
REQ-004 Parameter REPEAT_RATE, default 10_000_000, cycles between subsequent auto-repeat pulses (0.1 s); values below 1 SHALL fail elaboration.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_in  input  N_CH  raw asynchronous inputs, one bit per channel.
REQ-008 btn_level  output  N_CH  debounced level per channel.
REQ-009 btn_press  output  N_CH  one-cycle pulse on accepted 0->1 transition.
REQ-010 btn_release  output  N_CH  one-cycle pulse on accepted 1->0 transition.
REQ-011 btn_repeat  output  N_CH  one-cycle auto-repeat pulse while held.

Function
REQ-012 Each channel SHALL pass btn_in through a private 2-FF synchronizer (sync0, sync1); channels SHALL share no state.
REQ-013 Per channel, a counter sized $clog2(STABLE_CYCLES) bits SHALL increment each cycle sync1 != btn_level and clear to 0 in any cycle sync1 == btn_level.
REQ-014 When sync1 != btn_level and counter == STABLE_CYCLES-1, the next edge SHALL load btn_level <= sync1 and counter <= 0; the counter SHALL never exceed STABLE_CYCLES-1.
REQ-015 Latency: a btn_in change held constant SHALL appear on btn_level exactly STABLE_CYCLES+1 edges after the edge that first samples it into sync0.
REQ-016 A glitch shorter than STABLE_CYCLES cycles at sync1 SHALL produce no change on any output.
REQ-017 btn_press (btn_release) SHALL be registered and high exactly in the first cycle btn_level reads 1 (0), low otherwise; never both high on one channel.
REQ-018 Simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-019 Asserting reset SHALL immediately clear sync0, sync1, counters, repeat state and all outputs to 0, at any point including mid-count.
REQ-020 No pulse output SHALL be generated by reset assertion or deassertion itself.
REQ-021 After reset release with btn_in held 1, btn_press SHALL occur as a normal debounced 0->1 transition per REQ-015.

Configuration
REQ-022 Macro DEBOUNCE_REPEAT_EN SHALL compile in the auto-repeat logic; when undefined, btn_repeat SHALL be constant 0 and no hold counters SHALL be synthesised.
REQ-023 With DEBOUNCE_REPEAT_EN, a per-channel hold counter SHALL start at 0 in the btn_press cycle and count every cycle btn_level == 1.
REQ-024 First btn_repeat pulse SHALL occur REPEAT_DELAY cycles after the btn_press cycle; subsequent pulses every REPEAT_RATE cycles thereafter while btn_level stays 1.
REQ-025 btn_repeat SHALL never coincide with btn_press or btn_release; the hold counter SHALL clear when btn_level falls and SHALL not wrap.

Verification (N_CH=3, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-026 btn_in[0] 0->1 held -> btn_level[0] rises 5 edges after sampling edge, btn_press[0] high exactly 1 cycle, other channels quiet.
REQ-027 btn_in[1] pulsed high for 3 cycles, repeated 5 times with 1-cycle gaps -> btn_level[1] stays 0, no pulses.
REQ-028 All three inputs rise on one edge -> btn_press = 3'b111 in a single cycle; later all fall -> btn_release = 3'b111 in a single cycle.
REQ-029 reset asserted asynchronously when counter == 2 on channel 2 -> all outputs 0 immediately; after release with btn_in[2]=1, btn_press[2] occurs 5 edges after the first sampling edge.
REQ-030 DEBOUNCE_REPEAT_EN defined, btn_in[0] held 30 cycles past press -> btn_repeat[0] at press+10, +13, +16, +19, +22, +25, +28, +31..., stops on release; undefined -> btn_repeat stays 0.
